// File: rtl/tracker_synth.sv
// N-channel step-sequenced tone synth: frame-tick sequencer, per-channel phase oscillator,
// waveform gate and decaying envelope, summed into a one-pole low-pass and a 1-bit PWM DAC.
module tracker_synth #(
  parameter int NUM_CH         = 2,
  parameter int SONG_LEN       = 288,
  parameter int TICKS_PER_STEP = 6,
  parameter int PHASE_W        = 16,
  parameter int VOL_W          = 6,
  parameter int LPF_SHIFT      = 3,
  localparam int SP_W          = $clog2(SONG_LEN),
  localparam int MIX_W         = VOL_W + $clog2(NUM_CH + 1),
  localparam int LPF_W         = MIX_W + LPF_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  frame_tick,
  input  logic                  run,
  input  logic                  restart,
  input  logic [8*NUM_CH-1:0]   ch_inc,
  input  logic [2*NUM_CH-1:0]   ch_oct,
  input  logic [2*NUM_CH-1:0]   ch_mode,
  input  logic [NUM_CH-1:0]     ch_trig,
  input  logic [2*NUM_CH-1:0]   ch_decay,
  output logic [SP_W-1:0]       songpos,
  output logic                  step_strobe,
  output logic [NUM_CH-1:0]     ch_gate,
  output logic [LPF_W-1:0]      audio_level,
  output logic                  audio_pwm
);

  localparam int TC_W = $clog2(TICKS_PER_STEP);
  localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};

  // Galois-free Fibonacci step for x^15 + x^14 + 1.
  function automatic logic [14:0] lfsr_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  logic [SP_W-1:0]                  songpos_r, songpos_s;
  logic [TC_W-1:0]                  tick_cnt_r, tick_cnt_s;
  logic                             trig_pend_r, trig_pend_s;
  logic                             step_strobe_r, step_strobe_s;
  logic [NUM_CH-1:0][VOL_W-1:0]     vol_r, vol_s;
  logic [NUM_CH-1:0][PHASE_W-1:0]   phase_r;
  logic [NUM_CH-1:0][14:0]          lfsr_r;
  logic [NUM_CH-1:0]                prev_sel_r, sel_s, gate_s, ch_gate_r;
  logic [MIX_W-1:0]                 mix_s;
  logic [LPF_W-1:0]                 lpf_r, pwm_acc_r;
  logic                             audio_pwm_r;

  // Sequencer and envelope next state; restart wins, then step/decay, then a pending trigger.
  always_comb begin
    songpos_s     = songpos_r;
    tick_cnt_s    = tick_cnt_r;
    trig_pend_s   = 1'b0;
    step_strobe_s = 1'b0;
    vol_s         = vol_r;
    if (restart) begin
      songpos_s   = {SP_W{1'b0}};
      tick_cnt_s  = {TC_W{1'b0}};
      vol_s       = '0;
      trig_pend_s = 1'b1;
    end else begin
      if (run && frame_tick) begin
        if (tick_cnt_r == TC_W'(TICKS_PER_STEP - 1)) begin
          tick_cnt_s  = {TC_W{1'b0}};
          songpos_s   = (songpos_r == SP_W'(SONG_LEN - 1)) ? {SP_W{1'b0}} : songpos_r + SP_W'(1);
          trig_pend_s = 1'b1;
        end else begin
          tick_cnt_s = tick_cnt_r + TC_W'(1);
          for (int c = 0; c < NUM_CH; c++) begin
            if (ch_decay[2*c +: 2] != 2'd0) begin
              vol_s[c] = vol_r[c] - (vol_r[c] >> ch_decay[2*c +: 2]);
            end else begin
              vol_s[c] = vol_r[c];
            end
          end
        end
      end else begin
        tick_cnt_s = tick_cnt_r;
      end
      if (trig_pend_r) begin
        step_strobe_s = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_trig[c]) begin
            vol_s[c] = VOL_MAX;
          end else begin
            vol_s[c] = vol_s[c];
          end
        end
      end else begin
        step_strobe_s = 1'b0;
      end
    end
  end

  // Waveform gate per channel from the octave-selected phase bits or the channel LFSR.
  always_comb begin
    sel_s  = '0;
    gate_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [PHASE_W-1:0] sh;
      sh       = phase_r[c] << ch_oct[2*c +: 2];
      sel_s[c] = sh[PHASE_W-1];
      case (ch_mode[2*c +: 2])
        2'd0:    gate_s[c] = sh[PHASE_W-1];
        2'd1:    gate_s[c] = sh[PHASE_W-1] & sh[PHASE_W-2];
        2'd2:    gate_s[c] = sh[PHASE_W-1] & sh[PHASE_W-2] & sh[PHASE_W-3];
        2'd3:    gate_s[c] = lfsr_r[c][0];
        default: gate_s[c] = 1'b0;
      endcase
    end
  end

  // Voice mixer: sum of gated envelope levels.
  always_comb begin
    mix_s = {MIX_W{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (gate_s[c]) begin
        mix_s = mix_s + MIX_W'(vol_r[c]);
      end else begin
        mix_s = mix_s;
      end
    end
  end

  // All state: sequencer, oscillators, noise, low-pass and PWM accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      songpos_r     <= {SP_W{1'b0}};
      tick_cnt_r    <= {TC_W{1'b0}};
      trig_pend_r   <= 1'b0;
      step_strobe_r <= 1'b0;
      vol_r         <= '0;
      phase_r       <= '0;
      lfsr_r        <= {NUM_CH{15'h7FFF}};
      prev_sel_r    <= '0;
      ch_gate_r     <= '0;
      lpf_r         <= {LPF_W{1'b0}};
      pwm_acc_r     <= {LPF_W{1'b0}};
      audio_pwm_r   <= 1'b0;
    end else begin
      songpos_r     <= songpos_s;
      tick_cnt_r    <= tick_cnt_s;
      trig_pend_r   <= trig_pend_s;
      step_strobe_r <= step_strobe_s;
      vol_r         <= vol_s;
      prev_sel_r    <= sel_s;
      ch_gate_r     <= gate_s;
      for (int c = 0; c < NUM_CH; c++) begin
        if (sample_tick) begin
          phase_r[c] <= phase_r[c] + {{(PHASE_W-8){1'b0}}, ch_inc[8*c +: 8]};
        end
        if (sel_s[c] && !prev_sel_r[c]) begin
          lfsr_r[c] <= lfsr_step(lfsr_r[c]);
        end
      end
      if (sample_tick) begin
        lpf_r <= lpf_r + LPF_W'(mix_s) - (lpf_r >> LPF_SHIFT);
      end
      {audio_pwm_r, pwm_acc_r} <= {1'b0, pwm_acc_r} + {1'b0, lpf_r};
    end
  end

  assign songpos     = songpos_r;
  assign step_strobe = step_strobe_r;
  assign ch_gate     = ch_gate_r;
  assign audio_level = lpf_r;
  assign audio_pwm   = audio_pwm_r;

endmodule

// File: tb/tb_tracker_synth.sv
// Directed bench for tracker_synth: expected values are queued as stimulus is applied and
// popped when the corresponding DUT state is sampled.
module tb_tracker_synth;
  localparam int NUM_CH = 2;

  logic                  clk = 1'b0;
  logic                  reset, sample_tick, frame_tick, run, restart;
  logic [8*NUM_CH-1:0]   ch_inc;
  logic [2*NUM_CH-1:0]   ch_oct, ch_mode, ch_decay;
  logic [NUM_CH-1:0]     ch_trig;
  logic [8:0]            songpos;
  logic                  step_strobe;
  logic [NUM_CH-1:0]     ch_gate;
  logic [10:0]           audio_level;
  logic                  audio_pwm;

  logic [31:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tracker_synth dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .frame_tick(frame_tick),
    .run(run), .restart(restart), .ch_inc(ch_inc), .ch_oct(ch_oct), .ch_mode(ch_mode),
    .ch_trig(ch_trig), .ch_decay(ch_decay), .songpos(songpos), .step_strobe(step_strobe),
    .ch_gate(ch_gate), .audio_level(audio_level), .audio_pwm(audio_pwm)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %0d, nothing expected in queue", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %0d, nothing expected in queue", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs + 32'd1 >= e && obs <= e + 32'd1) else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d +-1", tag, obs, e);
      end
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    int strobes, maxpos, cnt;
    reset = 1'b1; sample_tick = 1'b0; frame_tick = 1'b0; run = 1'b0; restart = 1'b0;
    ch_inc = '0; ch_oct = '0; ch_mode = '0; ch_trig = '0; ch_decay = '0;

    // reset state
    do_reset();
    push(32'd0); check("rst_songpos", 32'(songpos));
    push(32'd0); check("rst_strobe", 32'(step_strobe));
    push(32'd0); check("rst_gate", 32'(ch_gate));
    push(32'd0); check("rst_level", 32'(audio_level));
    push(32'd0); check("rst_pwm", 32'(audio_pwm));

    // first step: sixth frame tick advances, strobe and trigger a cycle later
    run = 1'b1; ch_trig = 2'b11;
    repeat (5) frame();
    push(32'd0); check("songpos_5ticks", 32'(songpos));
    frame();
    push(32'd1); check("songpos_6ticks", 32'(songpos));
    push(32'd0); check("strobe_at_adv", 32'(step_strobe));
    cyc(1);
    push(32'd1); check("strobe_after", 32'(step_strobe));
    push(32'd63); check("trig_vol0", 32'(dut.vol_r[0]));
    push(32'd63); check("trig_vol1", 32'(dut.vol_r[1]));
    cyc(1);
    push(32'd0); check("strobe_one_cycle", 32'(step_strobe));

    // decay: ch0 shift 3, ch1 shift 2
    ch_trig = 2'b00; ch_decay = {2'd2, 2'd3};
    push(32'd56); push(32'd48);
    frame();
    check("decay3_a", 32'(dut.vol_r[0])); check("decay2_a", 32'(dut.vol_r[1]));
    push(32'd49); push(32'd36);
    frame();
    check("decay3_b", 32'(dut.vol_r[0])); check("decay2_b", 32'(dut.vol_r[1]));
    ch_decay = 4'b0000;
    repeat (3) frame();
    push(32'd49); push(32'd36);
    check("decay0_hold0", 32'(dut.vol_r[0])); check("decay0_hold1", 32'(dut.vol_r[1]));
    ch_trig = 2'b01;
    frame();
    cyc(1);
    push(32'd63); push(32'd36);
    check("trig_mask_v0", 32'(dut.vol_r[0])); check("trig_mask_v1", 32'(dut.vol_r[1]));
    frame();
    push(32'd63); check("decay0_63", 32'(dut.vol_r[0]));

    // pause freezes sequencer and envelope
    ch_decay = 4'b1111; run = 1'b0;
    repeat (10) frame();
    push(32'd2); check("pause_songpos", 32'(songpos));
    push(32'd1); check("pause_tick", 32'(dut.tick_cnt_r));
    push(32'd63); check("pause_vol0", 32'(dut.vol_r[0]));
    run = 1'b1; ch_decay = 4'b0000;

    // restart mid-step beats a coincident frame tick
    repeat (2) frame();
    ch_trig = 2'b10;
    frame_tick = 1'b1; restart = 1'b1;
    cyc(1);
    frame_tick = 1'b0; restart = 1'b0;
    push(32'd0); check("rs_songpos", 32'(songpos));
    push(32'd0); check("rs_tick", 32'(dut.tick_cnt_r));
    push(32'd0); check("rs_vol0", 32'(dut.vol_r[0]));
    push(32'd0); check("rs_strobe0", 32'(step_strobe));
    cyc(1);
    push(32'd1); check("rs_strobe1", 32'(step_strobe));
    push(32'd63); check("rs_vol1", 32'(dut.vol_r[1]));
    push(32'd0); check("rs_vol0_after", 32'(dut.vol_r[0]));
    cyc(1);

    // full song loop: 288 steps, one strobe each, wrap 287 -> 0
    strobes = 0; maxpos = 0;
    for (int i = 0; i < 288 * 6; i++) begin
      frame();
      if (step_strobe) strobes++;
      if (int'(songpos) > maxpos) maxpos = int'(songpos);
      cyc(1);
      if (step_strobe) strobes++;
      if (i == 287 * 6 - 1) begin
        push(32'd287); check("songpos_287", 32'(songpos));
      end
    end
    push(32'd0); check("wrap_songpos", 32'(songpos));
    push(32'd0); check("wrap_tick", 32'(dut.tick_cnt_r));
    push(32'd288); check("wrap_strobes", 32'(strobes));
    push(32'd287); check("wrap_maxpos", 32'(maxpos));

    // pulse modes: inc 0x40, octave 0, four full periods
    do_reset();
    run = 1'b0; ch_inc = {8'h00, 8'h40}; ch_oct = '0; ch_mode = {2'd0, 2'd1};
    push(32'd1024);
    cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      sample_tick = 1'b1; cyc(1); sample_tick = 1'b0; cyc(1);
      if (ch_gate[0]) cnt++;
    end
    check("pulse25_count", 32'(cnt));
    ch_mode = {2'd0, 2'd2};
    push(32'd512);
    cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      sample_tick = 1'b1; cyc(1); sample_tick = 1'b0; cyc(1);
      if (ch_gate[0]) cnt++;
    end
    check("pulse12_count", 32'(cnt));

    // LPF settles to 504 with one voice at 63, gate held by noise with a static phase
    do_reset();
    ch_inc = '0; ch_mode = {2'd0, 2'd3}; ch_trig = 2'b01; ch_decay = '0;
    run = 1'b1; restart = 1'b1; cyc(1); restart = 1'b0; cyc(1);
    run = 1'b0;
    cyc(1);
    push(32'd1); check("noise_gate", 32'(ch_gate));
    sample_tick = 1'b1; cyc(300); sample_tick = 1'b0; cyc(1);
    push(32'd504); check("lpf_settled", 32'(audio_level));
    // PWM accumulator is 11 bits, so 504 carries per 2048 clocks
    push(32'd504);
    cnt = 0;
    for (int i = 0; i < 2048; i++) begin
      cyc(1);
      if (audio_pwm) cnt++;
    end
    check_near("pwm_duty", 32'(cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
